// File: rtl/r5p_gpr_fetch.sv
// Operand fetch sequencer: reads rs1/rs2 through one async GPR read port.
// Define R5P_GPR_FETCH_SNOOP_EN to enable write snooping and forwarding.
module r5p_gpr_fetch #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en0_i,
    input  logic            req_vld_i,
    output logic            req_rdy_o,
    input  logic            req_us1_i,
    input  logic            req_us2_i,
    input  logic [AW-1:0]   req_rs1_i,
    input  logic [AW-1:0]   req_rs2_i,
    output logic            e_rs_o,
    output logic [AW-1:0]   a_rs_o,
    input  logic [XLEN-1:0] d_rs_i,
    input  logic            e_rd_i,
    input  logic [AW-1:0]   a_rd_i,
    input  logic [XLEN-1:0] d_rd_i,
    output logic            rsp_vld_o,
    input  logic            rsp_rdy_i,
    output logic [XLEN-1:0] rsp_rs1_o,
    output logic [XLEN-1:0] rsp_rs2_o
);

    typedef enum logic [1:0] {
        IDLE,
        RS1,
        RS2,
        RSP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   adr1_q, adr1_d;
    logic [AW-1:0]   adr2_q, adr2_d;
    logic [AW-1:0]   a_rs_q, a_rs_d;
    logic            rd2_q, rd2_d;
    logic            snp1_q, snp1_d;
    logic            snp2_q, snp2_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;

    logic            need1, need2;
    logic            req_xfer;
    logic            hit_rd, hit1, hit2;
    logic [XLEN-1:0] rd_data;

    assign need1 = req_us1_i & ((|req_rs1_i) | en0_i);
    assign need2 = req_us2_i & ((|req_rs2_i) | en0_i);

    assign req_rdy_o = (state_q == IDLE) | ((state_q == RSP) & rsp_rdy_i);
    assign req_xfer  = req_vld_i & req_rdy_o;
    assign a_rs_o    = a_rs_q;

`ifdef R5P_GPR_FETCH_SNOOP_EN
    logic wen;

    assign wen    = e_rd_i & ((|a_rd_i) | en0_i);
    // snp*_q marks operands already read; forced-zero ones never get it
    assign hit_rd = wen & (a_rd_i == a_rs_q);
    assign hit1   = wen & snp1_q & (a_rd_i == adr1_q);
    assign hit2   = wen & snp2_q & (a_rd_i == adr2_q);

    assign rsp_rs1_o = ((state_q == RSP) & hit1) ? d_rd_i : op1_q;
    assign rsp_rs2_o = ((state_q == RSP) & hit2) ? d_rd_i : op2_q;
`else
    logic unused_snoop;

    assign hit_rd = 1'b0;
    assign hit1   = 1'b0;
    assign hit2   = 1'b0;

    assign unused_snoop = ^{e_rd_i, a_rd_i, d_rd_i, snp1_q, snp2_q};

    assign rsp_rs1_o = op1_q;
    assign rsp_rs2_o = op2_q;
`endif

    assign rd_data = hit_rd ? d_rd_i : d_rs_i;

    always_comb begin
        state_d   = state_q;
        adr1_d    = adr1_q;
        adr2_d    = adr2_q;
        a_rs_d    = a_rs_q;
        rd2_d     = rd2_q;
        snp1_d    = snp1_q;
        snp2_d    = snp2_q;
        op1_d     = hit1 ? d_rd_i : op1_q;
        op2_d     = hit2 ? d_rd_i : op2_q;
        e_rs_o    = 1'b0;
        rsp_vld_o = 1'b0;

        unique case (state_q)
            IDLE: begin
            end
            RS1: begin
                e_rs_o = 1'b1;
                op1_d  = rd_data;
                snp1_d = 1'b1;
                if (rd2_q) begin
                    state_d = RS2;
                    a_rs_d  = adr2_q;
                end else begin
                    state_d = RSP;
                end
            end
            RS2: begin
                e_rs_o  = 1'b1;
                op2_d   = rd_data;
                snp2_d  = 1'b1;
                state_d = RSP;
            end
            RSP: begin
                rsp_vld_o = 1'b1;
                if (rsp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // a new request overrides whatever the current state decided
        if (req_xfer) begin
            adr1_d = req_rs1_i;
            adr2_d = req_rs2_i;
            rd2_d  = need2;
            snp1_d = 1'b0;
            snp2_d = 1'b0;
            op1_d  = '0;
            op2_d  = '0;
            if (need1) begin
                state_d = RS1;
                a_rs_d  = req_rs1_i;
            end else if (need2) begin
                state_d = RS2;
                a_rs_d  = req_rs2_i;
            end else begin
                state_d = RSP;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr1_q  <= '0;
            adr2_q  <= '0;
            a_rs_q  <= '0;
            rd2_q   <= 1'b0;
            snp1_q  <= 1'b0;
            snp2_q  <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            adr1_q  <= adr1_d;
            adr2_q  <= adr2_d;
            a_rs_q  <= a_rs_d;
            rd2_q   <= rd2_d;
            snp1_q  <= snp1_d;
            snp2_q  <= snp2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

endmodule

// File: tb/tb_r5p_gpr_fetch.sv
// Scoreboard bench for r5p_gpr_fetch with a behavioural 1R/1W GPR array.
// Expectations follow R5P_GPR_FETCH_SNOOP_EN when it is defined.
module tb_r5p_gpr_fetch;

    localparam int AW   = 5;
    localparam int XLEN = 32;
`ifdef R5P_GPR_FETCH_SNOOP_EN
    localparam bit SNOOP = 1'b1;
`else
    localparam bit SNOOP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            en0;
    logic            req_vld;
    logic            req_rdy;
    logic            req_us1;
    logic            req_us2;
    logic [AW-1:0]   req_rs1;
    logic [AW-1:0]   req_rs2;
    logic            e_rs;
    logic [AW-1:0]   a_rs;
    logic [XLEN-1:0] d_rs;
    logic            e_rd;
    logic [AW-1:0]   a_rd;
    logic [XLEN-1:0] d_rd;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic [XLEN-1:0] rsp_rs1;
    logic [XLEN-1:0] rsp_rs2;

    r5p_gpr_fetch #(.AW(AW), .XLEN(XLEN)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en0_i     (en0),
        .req_vld_i (req_vld),
        .req_rdy_o (req_rdy),
        .req_us1_i (req_us1),
        .req_us2_i (req_us2),
        .req_rs1_i (req_rs1),
        .req_rs2_i (req_rs2),
        .e_rs_o    (e_rs),
        .a_rs_o    (a_rs),
        .d_rs_i    (d_rs),
        .e_rd_i    (e_rd),
        .a_rd_i    (a_rd),
        .d_rd_i    (d_rd),
        .rsp_vld_o (rsp_vld),
        .rsp_rdy_i (rsp_rdy),
        .rsp_rs1_o (rsp_rs1),
        .rsp_rs2_o (rsp_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register array without write bypass
    logic [XLEN-1:0] gpr [32];
    assign d_rs = gpr[a_rs];
    always @(posedge clk) begin
        if (e_rd) gpr[a_rd] <= d_rd;
    end

    logic [2*XLEN-1:0] sbq [$];
    logic [2*XLEN-1:0] sb_exp;
    int n_run = 0;
    int n_fail = 0;

    logic [AW-1:0]   b2b_a [3];
    logic [XLEN-1:0] b2b_d [3];

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic us1, input logic [AW-1:0] rs1,
                       input logic us2, input logic [AW-1:0] rs2,
                       input logic [XLEN-1:0] x1, input logic [XLEN-1:0] x2,
                       input bit push);
        req_vld = 1'b1;
        req_us1 = us1;
        req_rs1 = rs1;
        req_us2 = us2;
        req_rs2 = rs2;
        if (push) sbq.push_back({x1, x2});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        e_rd = 1'b1;
        a_rd = a;
        d_rd = d;
        tick;
        e_rd = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick;
        chk("drain", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_vld && rsp_rdy) begin
            if (sbq.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                sb_exp = sbq.pop_front();
                chk("rsp_rs1", rsp_rs1, sb_exp[2*XLEN-1:XLEN]);
                chk("rsp_rs2", rsp_rs2, sb_exp[XLEN-1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  last;
        bit  done;

        b2b_a = '{5'd3, 5'd5, 5'd7};
        b2b_d = '{32'h11, 32'h99, 32'hDEAD};
        rst = 1'b1;
        en0 = 1'b0;
        req_vld = 1'b0;
        req_us1 = 1'b0;
        req_us2 = 1'b0;
        req_rs1 = '0;
        req_rs2 = '0;
        e_rd = 1'b0;
        a_rd = '0;
        d_rd = '0;
        rsp_rdy = 1'b0;
        repeat (2) tick;
        chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        chk("rst_e_rs", 32'(e_rs), 32'd0);
        chk("rst_a_rs", 32'(a_rs), 32'd0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rs1", rsp_rs1, 32'd0);
        chk("rst_rs2", rsp_rs2, 32'd0);
        rst = 1'b0;
        tick;

        wr(5'd3, 32'h11);
        wr(5'd5, 32'h22);
        wr(5'd7, 32'h1234);
        wr(5'd0, 32'h5A);

        // two reads
        req(1'b1, 5'd3, 1'b1, 5'd5, 32'h11, 32'h22, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t1_e_rs_c1", 32'(e_rs), 32'd1);
        chk("t1_a_rs_c1", 32'(a_rs), 32'd3);
        chk("t1_vld_c1", 32'(rsp_vld), 32'd0);
        tick;
        chk("t1_e_rs_c2", 32'(e_rs), 32'd1);
        chk("t1_a_rs_c2", 32'(a_rs), 32'd5);
        tick;
        chk("t1_vld_c3", 32'(rsp_vld), 32'd1);
        chk("t1_e_rs_c3", 32'(e_rs), 32'd0);
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;
        chk("t1_vld_after", 32'(rsp_vld), 32'd0);

        // x0 forced to zero, rs2 unused
        req(1'b1, 5'd0, 1'b0, 5'd9, 32'd0, 32'd0, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t2_vld_c1", 32'(rsp_vld), 32'd1);
        chk("t2_e_rs", 32'(e_rs), 32'd0);
        chk("t2_a_rs_hold", 32'(a_rs), 32'd5);
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;

        // x0 as ordinary register
        en0 = 1'b1;
        req(1'b1, 5'd0, 1'b0, 5'd0, 32'h5A, 32'd0, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t2b_e_rs", 32'(e_rs), 32'd1);
        chk("t2b_a_rs", 32'(a_rs), 32'd0);
        tick;
        chk("t2b_vld", 32'(rsp_vld), 32'd1);
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;
        en0 = 1'b0;

        // write in the same cycle as the read of x7
        req(1'b1, 5'd7, 1'b0, 5'd0,
            SNOOP ? 32'hDEAD : 32'h1234, 32'd0, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t3_a_rs", 32'(a_rs), 32'd7);
        e_rd = 1'b1;
        a_rd = 5'd7;
        d_rd = 32'hDEAD;
        tick;
        e_rd = 1'b0;
        chk("t3_vld", 32'(rsp_vld), 32'd1);
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;

        // snoop while held in RSP
        req(1'b1, 5'd3, 1'b1, 5'd5,
            32'h11, SNOOP ? 32'h99 : 32'h22, 1'b1);
        repeat (3) tick;
        req_vld = 1'b0;
        chk("t4_vld", 32'(rsp_vld), 32'd1);
        chk("t4_rs2_pre", rsp_rs2, 32'h22);
        e_rd = 1'b1;
        a_rd = 5'd5;
        d_rd = 32'h99;
        tick;
        e_rd = 1'b0;
        chk("t4_rs2_post", rsp_rs2, SNOOP ? 32'h99 : 32'h22);
        chk("t4_rs1_post", rsp_rs1, 32'h11);
        tick;
        chk("t4_vld_hold", 32'(rsp_vld), 32'd1);
        tick;
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;

        // forced-zero rs1 with a write to x0 while held
        req(1'b1, 5'd0, 1'b1, 5'd5, 32'd0, 32'h99, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t4b_a_rs", 32'(a_rs), 32'd5);
        chk("t4b_e_rs", 32'(e_rs), 32'd1);
        tick;
        e_rd = 1'b1;
        a_rd = 5'd0;
        d_rd = 32'hBEEF;
        tick;
        e_rd = 1'b0;
        chk("t4b_rs1_x0", rsp_rs1, 32'd0);
        rsp_rdy = 1'b1;
        tick;
        rsp_rdy = 1'b0;

        // back-to-back single-read requests
        rsp_rdy = 1'b1;
        cyc = 0;
        last = 0;
        for (int k = 0; k < 3; k++) begin
            req(1'b1, b2b_a[k], 1'b0, 5'd0, b2b_d[k], 32'd0, 1'b1);
            done = 1'b0;
            for (int i = 0; i < 10 && !done; i++) begin
                if (rsp_vld) chk("b2b_rdy_in_rsp", 32'(req_rdy), 32'd1);
                done = req_rdy;
                tick;
                cyc++;
            end
            if (!done) chk("b2b_timeout", 32'd0, 32'd1);
            if (k > 0) chk("b2b_interval", 32'(cyc - last), 32'd2);
            last = cyc;
        end
        req_vld = 1'b0;
        drain;
        rsp_rdy = 1'b0;
        tick;

        // asynchronous reset during RS2
        req(1'b1, 5'd3, 1'b1, 5'd5, 32'd0, 32'd0, 1'b0);
        tick;
        req_vld = 1'b0;
        tick;
        chk("t6_e_rs_rs2", 32'(e_rs), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("t6_req_rdy", 32'(req_rdy), 32'd1);
        chk("t6_e_rs", 32'(e_rs), 32'd0);
        chk("t6_a_rs", 32'(a_rs), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        req(1'b1, 5'd5, 1'b1, 5'd3, 32'h99, 32'h11, 1'b1);
        tick;
        req_vld = 1'b0;
        chk("t6_a_rs_c1", 32'(a_rs), 32'd5);
        tick;
        chk("t6_a_rs_c2", 32'(a_rs), 32'd3);
        tick;
        chk("t6_vld_c3", 32'(rsp_vld), 32'd1);
        rsp_rdy = 1'b1;
        drain;
        rsp_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
